// File: rtl/write_line_queue.sv
// rtl/write_line_queue.sv - line write-back queue issuing one write at a time to the write channels manager
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   push            - enqueue request (one cycle per entry)
//   push_addr       - line address, bits [3:0] ignored
//   push_data       - 128-bit line data, word0 in bits [31:0]
//   q_full, q_empty - occupancy flags from the registered count (in-flight entry counts)
//   wb_ovf          - sticky: a push was dropped while the queue was full
//   wstart_rq       - one-cycle start pulse to the write channels manager
//   win_addr        - registered head address {addr[31:4], 4'b0}
//   in_wdata        - registered head data
//   finish_wresp    - one-cycle pulse: head write acknowledged
//   chk_addr        - read-path hazard lookup address, bits [3:0] ignored
//   chk_hit         - combinational: chk_addr line matches any valid entry

module write_line_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [31:0]  push_addr,
    input  logic [127:0] push_data,
    output logic         q_full,
    output logic         q_empty,
    output logic         wb_ovf,
    output logic         wstart_rq,
    output logic [31:0]  win_addr,
    output logic [127:0] in_wdata,
    input  logic         finish_wresp,
    input  logic [31:0]  chk_addr,
    output logic         chk_hit
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    state_t             state;
    logic [DEPTH-1:0]   valid;
    logic [27:0]        addr_mem [DEPTH];
    logic [127:0]       data_mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [PTR_W:0]     count;
    logic               push_ok;
    logic               pop;
    logic               unused_low_bits;

    // The low nibble of both addresses selects a byte inside the line and
    // plays no part in storage or matching.
    assign unused_low_bits = ^{push_addr[3:0], chk_addr[3:0]};

    assign q_full  = (count == FULL_CNT);
    assign q_empty = (count == '0);

    // Fullness comes from the registered count, so a pop in the same cycle
    // does not make room for a push.
    assign push_ok = push & ~q_full;
    assign pop     = (state == S_WAIT) & finish_wresp;

    // Entry payload needs no reset: it is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wptr] <= push_addr[31:4];
            data_mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            valid     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            wb_ovf    <= 1'b0;
            wstart_rq <= 1'b0;
            win_addr  <= '0;
            in_wdata  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (push && q_full) begin
                wb_ovf <= 1'b1;
            end

            // Push and pop slots can only coincide when the queue is full,
            // where the push is rejected, so the order here never matters.
            if (pop) begin
                valid[rptr] <= 1'b0;
            end
            if (push_ok) begin
                valid[wptr] <= 1'b1;
            end

            wstart_rq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        // Head is captured here and held through WAIT because
                        // the manager samples it after the start pulse.
                        state     <= S_ISSUE;
                        wstart_rq <= 1'b1;
                        win_addr  <= {addr_mem[rptr], 4'b0000};
                        in_wdata  <= data_mem[rptr];
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (finish_wresp) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The in-flight head keeps its valid bit until retired, so reads stay
    // stalled for the whole bus write.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i] == chk_addr[31:4])) begin
                chk_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_line_queue.sv
// tb/tb_write_line_queue.sv - scoreboard bench for write_line_queue

module tb_write_line_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         push;
    logic [31:0]  push_addr;
    logic [127:0] push_data;
    logic         q_full;
    logic         q_empty;
    logic         wb_ovf;
    logic         wstart_rq;
    logic [31:0]  win_addr;
    logic [127:0] in_wdata;
    logic         finish_wresp;
    logic [31:0]  chk_addr;
    logic         chk_hit;

    write_line_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_addr(push_addr),
        .push_data(push_data), .q_full(q_full), .q_empty(q_empty),
        .wb_ovf(wb_ovf), .wstart_rq(wstart_rq), .win_addr(win_addr),
        .in_wdata(in_wdata), .finish_wresp(finish_wresp),
        .chk_addr(chk_addr), .chk_hit(chk_hit)
    );

    always #5 clk = ~clk;

    entry_t      live_q[$];
    entry_t      exp_q[$];
    entry_t      cur;
    bit          outstanding = 0;
    bit          ovf_exp = 0;
    bit          prev_start = 0;
    int          cyc_cnt = 0;
    int          last_start_cyc = 0;
    int          start_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] chk_val = 32'h0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        foreach (live_q[i]) begin
            if (live_q[i].addr[31:4] == a[31:4]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock of stimulus; the model applies the queue rules at the edge.
    task automatic cyc(input bit p, input logic [31:0] a, input logic [127:0] d, input bit f);
        bit     f_real;
        bit     acc;
        entry_t e;
        entry_t tmp;
        push         = p;
        push_addr    = a;
        push_data    = d;
        finish_wresp = f;
        chk_addr     = chk_val;
        f_real       = f && outstanding;
        e.addr       = {a[31:4], 4'b0000};
        e.data       = d;
        @(posedge clk);
        cyc_cnt++;
        if (rst_n) begin
            acc = p && (live_q.size() < DEPTH);
            if (p && !acc) ovf_exp = 1'b1;
            if (f_real) begin
                tmp = live_q.pop_front();
                outstanding = 1'b0;
            end
            if (acc) begin
                live_q.push_back(e);
                exp_q.push_back(e);
            end
        end
        #2;
        push         = 1'b0;
        finish_wresp = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 128'h0, 1'b0);
    endtask

    function automatic logic [127:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_start();
        int n = 0;
        while (!outstanding && n < 20) begin
            idle(1);
            n++;
        end
        checks++;
        if (!outstanding) begin
            errors++;
            $display("FAIL wait_start: no wstart_rq within 20 cycles (t=%0t)", $time);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (live_q.size() != 0 && guard < 20) begin
            wait_start();
            cyc(1'b0, 32'h0, 128'h0, 1'b1);
            guard++;
        end
        check("drain_empty", q_empty, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q_empty"}, q_empty, 1'b1);
        check({tag, "_q_full"}, q_full, 1'b0);
        check({tag, "_wb_ovf"}, wb_ovf, 1'b0);
        check({tag, "_wstart_rq"}, wstart_rq, 1'b0);
        check({tag, "_win_addr"}, win_addr, 32'h0);
        check({tag, "_in_wdata"}, in_wdata, 128'h0);
        check({tag, "_chk_hit"}, chk_hit, 1'b0);
    endtask

    // Monitor: compares every observable output with the model each cycle and
    // checks each issued write against the scoreboard queue.
    always @(negedge clk) begin
        entry_t e;
        if (rst_n) begin
            check("q_full", q_full, live_q.size() == DEPTH);
            check("q_empty", q_empty, live_q.size() == 0);
            check("wb_ovf", wb_ovf, ovf_exp);
            check("chk_hit", chk_hit, model_hit(chk_addr));
            if (wstart_rq) begin
                check("start_pulse_width", prev_start, 1'b0);
                check("start_while_busy", outstanding, 1'b0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: wstart_rq with no queued entry, win_addr=%0h (t=%0t)", win_addr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_addr", win_addr, e.addr);
                    check("issue_data", in_wdata, e.data);
                    cur = e;
                end
                outstanding    = 1'b1;
                last_start_cyc = cyc_cnt;
                start_cnt++;
            end else if (outstanding) begin
                check("hold_addr", win_addr, cur.addr);
                check("hold_data", in_wdata, cur.data);
            end
            prev_start = wstart_rq;
        end else begin
            prev_start = 1'b0;
        end
    end

    initial begin
        int          push_cyc;
        int          fin_cyc;
        int          starts0;
        logic [31:0] a;

        rst_n        = 1'b0;
        push         = 1'b0;
        push_addr    = 32'h0;
        push_data    = 128'h0;
        finish_wresp = 1'b0;
        chk_addr     = 32'h0;
        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Single entry: alignment, data, push-to-start latency, retirement.
        cyc(1'b1, 32'h0000_1234, 128'h44444444_33333333_22222222_11111111, 1'b0);
        push_cyc = cyc_cnt;
        wait_start();
        check("push_to_start", last_start_cyc - push_cyc, 1);
        check("single_win_addr", win_addr, 32'h0000_1230);
        check("single_in_wdata", in_wdata, 128'h44444444_33333333_22222222_11111111);
        cyc(1'b0, 32'h0, 128'h0, 1'b1);
        check("single_empty_after", q_empty, 1'b1);
        idle(2);

        // Fill, overflow, in-order drain, finish-to-start latency.
        starts0 = start_cnt;
        for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h100 * i, rnd_data(), 1'b0);
        check("fill_full", q_full, 1'b1);
        cyc(1'b1, 32'h500, rnd_data(), 1'b0);
        check("fill_ovf", wb_ovf, 1'b1);
        wait_start();
        cyc(1'b0, 32'h0, 128'h0, 1'b1);
        fin_cyc = cyc_cnt;
        wait_start();
        check("finish_to_start", last_start_cyc - fin_cyc, 1);
        drain();
        check("fill_start_count", start_cnt - starts0, 4);
        check("fill_ovf_sticky", wb_ovf, 1'b1);

        // Same-cycle push and finish: rejected when full, accepted at count 2.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h600 + 32'h10 * i, rnd_data(), 1'b0);
        wait_start();
        cyc(1'b1, 32'h700, rnd_data(), 1'b1);
        check("full_pushpop_not_full", q_full, 1'b0);
        wait_start();
        cyc(1'b0, 32'h0, 128'h0, 1'b1);
        wait_start();
        cyc(1'b1, 32'h800, rnd_data(), 1'b1);
        check("cnt2_pushpop_size", live_q.size(), 2);
        drain();

        // Hazard lookup on a queued / in-flight line.
        chk_val = 32'h0000_200C;
        cyc(1'b1, 32'h0000_2000, rnd_data(), 1'b0);
        check("hazard_queued", chk_hit, 1'b1);
        wait_start();
        idle(1);
        check("hazard_wait", chk_hit, 1'b1);
        chk_val = 32'h0000_2010;
        idle(1);
        check("hazard_next_line", chk_hit, 1'b0);
        chk_val = 32'h0000_200C;
        cyc(1'b0, 32'h0, 128'h0, 1'b1);
        check("hazard_retired", chk_hit, 1'b0);
        idle(2);

        // Spurious finish while idle and empty.
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 128'h0, 1'b1);
        check("spurious_win_addr", win_addr, cur.addr);
        check("spurious_empty", q_empty, 1'b1);
        cyc(1'b1, 32'h0000_3000, rnd_data(), 1'b0);
        drain();

        // Reset in the middle of a write with three entries queued.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h4000 + 32'h10 * i, rnd_data(), 1'b0);
        wait_start();
        chk_val = 32'h0000_4000;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        live_q.delete();
        exp_q.delete();
        outstanding = 1'b0;
        ovf_exp     = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(10);
        cyc(1'b1, 32'h0000_5000, rnd_data(), 1'b0);
        drain();

        // Randomized traffic over a small address pool for duplicates and hits.
        for (int n = 0; n < 400; n++) begin
            bit p;
            bit f;
            p = ($urandom % 2) == 0;
            a = 32'h0000_6000 + (($urandom % 6) << 4) + ($urandom % 16);
            f = outstanding ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            chk_val = 32'h0000_6000 + (($urandom % 7) << 4) + ($urandom % 16);
            cyc(p, a, rnd_data(), f);
        end
        drain();
        idle(4);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_line_queue.md
Name: write_line_queue

Overview:
- Buffers 128-bit line write-backs (cache evictions or uncached line stores) from the core side.
- Issues them one at a time to the write channels manager through its wstart_rq / win_addr / in_wdata interface.
- Retires each entry only when finish_wresp returns, so at most one write is outstanding on the bus.
- Provides an address-hazard lookup so the read path can stall while a matching line write is still queued or in flight.

Parameters:
- DEPTH, 4, number of queued line entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- push  input  1  enqueue request, one cycle per entry
- push_addr  input  32  line address; bits [3:0] are ignored
- push_data  input  128  line data; word0 = bits [31:0], sent first on W
- q_full  output  1  all DEPTH entries valid (registered count == DEPTH)
- q_empty  output  1  no valid entries (in-flight entry counts as valid)
- wb_ovf  output  1  sticky: a push was dropped because the queue was full
- wstart_rq  output  1  one-cycle start pulse to the write channels manager
- win_addr  output  32  head entry address, {addr[31:4], 4'b0}
- in_wdata  output  128  head entry data
- finish_wresp  input  1  one-cycle pulse: head write has been acknowledged on B
- chk_addr  input  32  read-path lookup address; bits [3:0] ignored
- chk_hit  output  1  combinational: chk_addr[31:4] matches any valid entry

Behaviour:
- Reset, asynchronous on rst_n low:
  - pointers and count = 0; all valid bits = 0; state = IDLE.
  - Outputs: q_empty=1, q_full=0, wb_ovf=0, wstart_rq=0, win_addr=0, in_wdata=0, chk_hit=0.
- Storage:
  - Circular buffer of DEPTH entries {valid, addr[31:4], data[127:0]}.
  - Write pointer and read pointer wrap modulo DEPTH.
  - count is PTR_W+1 bits wide.
- Push:
  - If push=1 and q_full=0: write the entry at wptr, set its valid bit, increment wptr and count at the clock edge.
  - If push=1 and q_full=1: the entry is dropped and wb_ovf is set. wb_ovf stays set until reset.
  - q_full is evaluated on the registered count. A push while full is rejected even if finish_wresp pops in the same cycle.
- Issue state machine, one outstanding write at a time:
  - IDLE: if count != 0, go to ISSUE.
  - ISSUE: wstart_rq=1 for exactly this one cycle; go to WAIT.
  - WAIT: hold until finish_wresp=1. Then clear the valid bit at rptr, increment rptr, decrement count, and go to IDLE.
  - Push and pop in the same cycle: count is unchanged; both pointers advance.
- Timing:
  - An entry pushed into an empty queue in IDLE at edge N produces wstart_rq in the cycle after edge N+1 (two-cycle push-to-start).
  - Back-to-back entries: wstart_rq for the next entry follows finish_wresp by 2 cycles (WAIT→IDLE→ISSUE).
- Head outputs:
  - win_addr and in_wdata are registered copies of the entry at rptr, loaded on the IDLE→ISSUE transition.
  - They are held stable from ISSUE through the cycle finish_wresp is seen, because the write channels manager samples them after wstart_rq.
  - They are not cleared after retirement.
- Spurious finish_wresp (in IDLE or ISSUE) is ignored and has no state change.
- Hazard check:
  - chk_hit = OR over entries of (valid && addr[31:4]==chk_addr[31:4]).
  - The in-flight head entry stays valid, and therefore matchable, until retired.
  - An entry pushed at edge N is matchable from cycle N+1.
- Duplicate addresses are allowed; entries drain in strict FIFO order, with no merging.
- rst_n asserted mid-write (WAIT) discards all entries. The bus-side manager is reset by the same rst_n.

Test Plan:
- Single entry: push addr 0x0000_1234, data 0x44444444_33333333_22222222_11111111 → win_addr=0x0000_1230, in_wdata equal to the pushed data, wstart_rq one-cycle pulse 2 cycles after push. Then finish_wresp → q_empty=1 one cycle later.
- Fill 4 entries with addr 0x100, 0x200, 0x300, 0x400 → q_full=1; 5th push → dropped, wb_ovf=1. Return finish_wresp 4 times → issue order 0x100, 0x200, 0x300, 0x400 with exactly 4 wstart_rq pulses; wb_ovf remains 1.
- Full queue, push and finish_wresp in the same cycle → push rejected, count drops to 3, wb_ovf=1. With count=2, same-cycle push+finish → count stays 2 and the pointers wrap correctly after 6 total pushes.
- Hazard: queue 0x0000_2000, chk_addr=0x0000_200C → chk_hit=1 while in WAIT. After finish_wresp → chk_hit=0. chk_addr=0x0000_2010 → chk_hit=0 throughout.
- finish_wresp pulsed in IDLE with an empty queue → no state, pointer, or output change; a later push still issues normally.
- Reset asserted during WAIT with 3 entries queued → all outputs return to reset values immediately, q_empty=1, no further wstart_rq until a new push.
